// File: rtl/cache_pkg.sv
// Shared constants and types for the cache slice; values reflect the default
// 4-way, 16-line, 256-word configuration.
package cache_pkg;

    localparam int DEF_WAYS       = 4;
    localparam int DEF_TOTAL_SIZE = 16;
    localparam int DEF_RAM_DEPTH  = 256;

    localparam int SETS    = DEF_TOTAL_SIZE / DEF_WAYS;
    localparam int INDEX_W = $clog2(SETS);
    localparam int WAY_W   = $clog2(DEF_WAYS);
    localparam int TAG_W   = $clog2(DEF_RAM_DEPTH) - INDEX_W;

    // One age per way, way 0 in the least-significant slot; age 0 is MRU.
    typedef logic [DEF_WAYS-1:0][WAY_W-1:0] age_vec_t;

endpackage

// File: rtl/cache_lru_set.sv
// Next-state logic for one set's age vector: the touched way becomes age 0 and
// every way younger than its old age moves one step older.
module cache_lru_set #(
    parameter int WAYS  = 4,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS*WAY_W-1:0] age,
    input  logic                  upd,
    input  logic [WAY_W-1:0]      way,
    output logic [WAYS*WAY_W-1:0] age_nxt
);

    logic [WAY_W-1:0] old_age;

    always_comb begin
        old_age = age[int'(way)*WAY_W +: WAY_W];
        age_nxt = age;
        if (upd) begin
            for (int i = 0; i < WAYS; i++) begin
                if (WAY_W'(i) == way) begin
                    age_nxt[i*WAY_W +: WAY_W] = '0;
                end else if (age[i*WAY_W +: WAY_W] < old_age) begin
                    // Cannot wrap: anything below old_age is at most WAYS-2.
                    age_nxt[i*WAY_W +: WAY_W] = age[i*WAY_W +: WAY_W] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cache_lru.sv
// True-LRU replacement state for a set-associative cache: per-set age
// permutations, updated on committed accesses, with combinational LRU/MRU lookup.
module cache_lru
    import cache_pkg::*;
#(
    parameter int WAYS       = DEF_WAYS,
    parameter int TOTAL_SIZE = DEF_TOTAL_SIZE,
    parameter int RAM_DEPTH  = DEF_RAM_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  access_valid,
    input  logic [$clog2(TOTAL_SIZE/WAYS)-1:0]    access_set,
    input  logic [$clog2(WAYS)-1:0]               access_way,
    input  logic                                  flush,
    input  logic [$clog2(TOTAL_SIZE/WAYS)-1:0]    lookup_set,
    output logic [$clog2(WAYS)-1:0]               lru_way,
    output logic [$clog2(WAYS)-1:0]               mru_way
);

    localparam int N_SETS = TOTAL_SIZE / WAYS;
    localparam int IDX_W  = $clog2(N_SETS);
    localparam int AW     = $clog2(WAYS);

    if ((WAYS < 2) || ((WAYS & (WAYS - 1)) != 0)) begin : g_bad_ways
        $error("cache_lru: WAYS must be a power of two and at least 2");
    end
    if (RAM_DEPTH < TOTAL_SIZE) begin : g_bad_depth
        $error("cache_lru: RAM_DEPTH smaller than TOTAL_SIZE");
    end

    logic [WAYS*AW-1:0] age_q   [N_SETS];
    logic [WAYS*AW-1:0] age_nxt [N_SETS];
    logic [WAYS*AW-1:0] look_age;

    // Reset ordering: way i has age WAYS-1-i, so way 0 is LRU and way WAYS-1 is MRU.
    function automatic logic [WAYS*AW-1:0] reset_order();
        logic [WAYS*AW-1:0] v;
        v = '0;
        for (int i = 0; i < WAYS; i++) begin
            v[i*AW +: AW] = AW'(WAYS - 1 - i);
        end
        return v;
    endfunction

    for (genvar s = 0; s < N_SETS; s++) begin : g_set
        cache_lru_set #(.WAYS(WAYS), .WAY_W(AW)) u_set (
            .age     (age_q[s]),
            .upd     (access_valid && (access_set == IDX_W'(s))),
            .way     (access_way),
            .age_nxt (age_nxt[s])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N_SETS; s++) age_q[s] <= reset_order();
        end else if (flush) begin
            for (int s = 0; s < N_SETS; s++) age_q[s] <= reset_order();
        end else begin
            for (int s = 0; s < N_SETS; s++) age_q[s] <= age_nxt[s];
        end
    end

    assign look_age = age_q[lookup_set];

    always_comb begin
        lru_way = '0;
        mru_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (look_age[i*AW +: AW] == AW'(WAYS - 1)) lru_way = AW'(i);
            if (look_age[i*AW +: AW] == '0)            mru_way = AW'(i);
        end
    end

endmodule

// File: tb/tb_cache_lru.sv
// Bench for cache_lru: table-driven directed cycles, a random phase and an
// asynchronous-reset sequence, all scored against a recency-list model.
module tb_cache_lru;

    localparam int WAYS = 4;
    localparam int SETS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       access_valid;
    logic [1:0] access_set;
    logic [1:0] access_way;
    logic       flush;
    logic [1:0] lookup_set;
    logic [1:0] lru_way;
    logic [1:0] mru_way;

    cache_lru #(.WAYS(4), .TOTAL_SIZE(16), .RAM_DEPTH(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .access_valid (access_valid),
        .access_set   (access_set),
        .access_way   (access_way),
        .flush        (flush),
        .lookup_set   (lookup_set),
        .lru_way      (lru_way),
        .mru_way      (mru_way)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // rec[s][0] is the MRU way of set s, rec[s][WAYS-1] the LRU way.
    int rec [SETS][WAYS];

    typedef struct {
        logic [1:0] lru;
        logic [1:0] mru;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic       v;
        logic [1:0] s;
        logic [1:0] w;
        logic       f;
        logic [1:0] ls;
        logic [1:0] el;
        logic [1:0] em;
    } vec_t;
    vec_t vecs[19];

    function automatic vec_t mk(input logic v, input logic [1:0] s, input logic [1:0] w,
                                input logic f, input logic [1:0] ls,
                                input logic [1:0] el, input logic [1:0] em);
        vec_t r;
        r.v = v; r.s = s; r.w = w; r.f = f; r.ls = ls; r.el = el; r.em = em;
        return r;
    endfunction

    task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int k = 0; k < WAYS; k++)
                rec[s][k] = WAYS - 1 - k;
    endtask

    task automatic model_access(input int s, input int w);
        int p;
        p = 0;
        for (int k = 0; k < WAYS; k++) if (rec[s][k] == w) p = k;
        for (int k = p; k > 0; k--) rec[s][k] = rec[s][k-1];
        rec[s][0] = w;
    endtask

    // One cycle: drive at the falling edge, score the pre-edge outputs, then
    // advance the model by what the coming rising edge will do.
    task automatic step(input logic v, input logic [1:0] s, input logic [1:0] w,
                        input logic f, input logic [1:0] ls, input string nm,
                        input bit has_exp, input logic [1:0] el, input logic [1:0] em);
        exp_t e;
        exp_t got;
        @(negedge clk);
        access_valid = v;
        access_set   = s;
        access_way   = w;
        flush        = f;
        lookup_set   = ls;
        e.lru = 2'(rec[ls][WAYS-1]);
        e.mru = 2'(rec[ls][0]);
        sb_q.push_back(e);
        #1;
        got = sb_q.pop_front();
        check({nm, " model lru"}, lru_way, got.lru);
        check({nm, " model mru"}, mru_way, got.mru);
        if (has_exp) begin
            check({nm, " table lru"}, lru_way, el);
            check({nm, " table mru"}, mru_way, em);
        end
        if (f) model_reset();
        else if (v) model_access(int'(s), int'(w));
    endtask

    initial begin
        rst          = 1'b1;
        access_valid = 1'b0;
        access_set   = '0;
        access_way   = '0;
        flush        = 1'b0;
        lookup_set   = '0;
        model_reset();

        // Reset values visible on every set while rst is held.
        for (int ls = 0; ls < SETS; ls++) begin
            lookup_set = 2'(ls);
            #1;
            check($sformatf("reset lru set%0d", ls), lru_way, 2'd0);
            check($sformatf("reset mru set%0d", ls), mru_way, 2'd3);
        end
        access_valid = 1'b1;
        access_way   = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        check("reset hold lru", lru_way, 2'd0);
        check("reset hold mru", mru_way, 2'd3);
        @(negedge clk);
        access_valid = 1'b0;
        rst = 1'b0;

        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 3);
        vecs[1]  = mk(0, 0, 0, 0, 1, 0, 3);
        vecs[2]  = mk(0, 0, 0, 0, 2, 0, 3);
        vecs[3]  = mk(0, 0, 0, 0, 3, 0, 3);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 3);
        vecs[5]  = mk(1, 0, 1, 0, 0, 1, 0);
        vecs[6]  = mk(1, 0, 2, 0, 0, 2, 1);
        vecs[7]  = mk(1, 0, 3, 0, 0, 3, 2);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 3);
        vecs[9]  = mk(1, 2, 3, 0, 2, 0, 3);
        vecs[10] = mk(0, 0, 0, 0, 2, 0, 3);
        vecs[11] = mk(1, 1, 2, 0, 1, 0, 3);
        vecs[12] = mk(0, 0, 0, 0, 1, 0, 2);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 3);
        vecs[14] = mk(1, 3, 0, 0, 3, 0, 3);
        vecs[15] = mk(1, 3, 2, 0, 3, 1, 0);
        vecs[16] = mk(1, 3, 1, 1, 3, 1, 2);
        vecs[17] = mk(0, 0, 0, 0, 3, 0, 3);
        vecs[18] = mk(0, 0, 0, 0, 1, 0, 3);

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].v, vecs[i].s, vecs[i].w, vecs[i].f, vecs[i].ls,
                 $sformatf("vec%0d", i), 1'b1, vecs[i].el, vecs[i].em);
        end

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
                 $sformatf("rand%0d", i), 1'b0, 2'd0, 2'd0);
        end

        // Asynchronous reset landing between edges in the middle of an access burst.
        step(0, 0, 0, 1, 0, "pre flush", 1'b0, 2'd0, 2'd0);
        step(1, 0, 1, 0, 0, "burst0", 1'b1, 2'd0, 2'd3);
        step(1, 0, 0, 0, 0, "burst1", 1'b1, 2'd0, 2'd1);
        @(negedge clk);
        access_valid = 1'b1;
        access_set   = 2'd0;
        access_way   = 2'd2;
        lookup_set   = 2'd0;
        #1;
        check("burst2 mru", mru_way, 2'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst lru", lru_way, 2'd0);
        check("async rst mru", mru_way, 2'd3);
        @(posedge clk);
        #1;
        check("rst over access lru", lru_way, 2'd0);
        check("rst over access mru", mru_way, 2'd3);
        @(negedge clk);
        access_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        step(1, 0, 0, 0, 0, "resume0", 1'b1, 2'd0, 2'd3);
        step(0, 0, 0, 0, 0, "resume1", 1'b1, 2'd1, 2'd0);
        step(0, 0, 0, 0, 2, "resume2", 1'b1, 2'd0, 2'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
